// File: rtl/gated_reg_scheduler.sv
// Round-robin scheduler granting NREQ requesters access to one enable-gated
// storage register, with a programmable lockout after each capture.
module gated_reg_scheduler #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int HOLD = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DW-1:0]       din,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          ack,
    output logic [DW-1:0]            q,
    output logic                     q_valid,
    output logic [$clog2(NREQ)-1:0]  q_owner
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_HOLD} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   gidx_q, gidx_d;
    logic [IW-1:0]   owner_q;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [DW-1:0]   data_q;
    logic            valid_q;
    logic [3:0]      cnt_q, cnt_d;
    logic            rearm_q, rearm_d;
    logic            we;
    logic            capture;
    logic            sel_found;
    logic [IW-1:0]   sel_idx;

    // Round-robin search starting at the pointer, wrapping at NREQ.
    always_comb begin
        int j;
        j         = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(ptr_q) + i) % NREQ;
            if (!sel_found && req[j]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(j);
            end
        end
    end

    assign capture = (state_q == S_GRANT) && req[gidx_q];

    // rearm_q inserts the re-arbitration cycle after every capture cycle-run.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        rearm_d = rearm_q;
        if (clr) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            ptr_d   = '0;
            rearm_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rearm_q) begin
                        rearm_d = 1'b0;
                    end else if (sel_found) begin
                        state_d = S_GRANT;
                        gidx_d  = sel_idx;
                    end
                end
                S_GRANT: begin
                    if (capture) begin
                        ptr_d = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
                        if (HOLD == 0) begin
                            state_d = S_IDLE;
                            rearm_d = 1'b1;
                        end else begin
                            state_d = S_HOLD;
                            cnt_d   = 4'(HOLD - 1);
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (cnt_q == '0) begin
                        state_d = S_IDLE;
                        rearm_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: every output of this block gets a default before any branch, so
    // no path leaves we/gnt_d/ack_d unassigned and no latch is inferred.
    always_comb begin
        we    = 1'b0;
        gnt_d = '0;
        ack_d = '0;
        if (!clr) begin
            if (state_q == S_IDLE && !rearm_q && sel_found)
                gnt_d = NREQ'(1) << sel_idx;
            if (capture) begin
                we    = 1'b1;
                ack_d = NREQ'(1) << gidx_q;
            end
        end
    end

    // NOTE: state uses non-blocking assignments only; the data register is
    // reset as well because q must read 0 while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            gidx_q  <= '0;
            rearm_q <= 1'b0;
            gnt_q   <= '0;
            ack_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            rearm_q <= rearm_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            if (clr) begin
                data_q  <= '0;
                valid_q <= 1'b0;
                owner_q <= '0;
            end else if (we) begin
                data_q  <= din[int'(gidx_q)*DW +: DW];
                valid_q <= 1'b1;
                owner_q <= gidx_q;
            end
        end
    end

    assign gnt     = gnt_q;
    assign ack     = ack_q;
    assign q       = data_q;
    assign q_valid = valid_q;
    assign q_owner = owner_q;

endmodule

// File: tb/tb_gated_reg_scheduler.sv
// Directed bench: a cycle table for the basic grant/capture/hold timing plus
// hand-written sequences for fairness, clear, async reset and HOLD=0.
module tb_gated_reg_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] din = 32'h3CA55A11;
    logic [3:0]  gnt, ack;
    logic [7:0]  q;
    logic        q_valid;
    logic [1:0]  q_owner;

    logic        clr_z = 1'b0;
    logic [3:0]  req_z = '0;
    logic [31:0] din_z = 32'h44332211;
    logic [3:0]  gnt_z, ack_z;
    logic [7:0]  q_z;
    logic        q_valid_z;
    logic [1:0]  q_owner_z;

    int n_cmp = 0;
    int n_fail = 0;

    gated_reg_scheduler #(.NREQ(4), .DW(8), .HOLD(2)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .req(req), .din(din),
        .gnt(gnt), .ack(ack), .q(q), .q_valid(q_valid), .q_owner(q_owner)
    );

    gated_reg_scheduler #(.NREQ(4), .DW(8), .HOLD(0)) dut_z (
        .clk(clk), .rst_n(rst_n), .clr(clr_z), .req(req_z), .din(din_z),
        .gnt(gnt_z), .ack(ack_z), .q(q_z), .q_valid(q_valid_z), .q_owner(q_owner_z)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [3:0] ack;
        logic [7:0] q;
        logic       qv;
        logic [1:0] own;
    } vec_t;

    vec_t vt[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (ack != 0) ok = 1'b1;
        end
    endtask

    task automatic wait_gnt(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (gnt != 0) ok = 1'b1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},   32'(gnt),     32'h0);
        check({tag, "_ack"},   32'(ack),     32'h0);
        check({tag, "_q"},     32'(q),       32'h0);
        check({tag, "_qv"},    32'(q_valid), 32'h0);
        check({tag, "_owner"}, 32'(q_owner), 32'h0);
    endtask

    initial begin
        bit   ok;
        int   caps, last_cyc;
        int   order[5];
        int   onehot_bad;
        logic [1:0] exp_own;

        //            req      gnt      ack      q      qv    own
        vt[0]  = '{4'b0100, 4'b0100, 4'b0000, 8'h00, 1'b0, 2'd0};
        vt[1]  = '{4'b0100, 4'b0000, 4'b0100, 8'hA5, 1'b1, 2'd2};
        vt[2]  = '{4'b0100, 4'b0000, 4'b0000, 8'hA5, 1'b1, 2'd2};
        vt[3]  = '{4'b0100, 4'b0000, 4'b0000, 8'hA5, 1'b1, 2'd2};
        vt[4]  = '{4'b0100, 4'b0000, 4'b0000, 8'hA5, 1'b1, 2'd2};
        vt[5]  = '{4'b0100, 4'b0100, 4'b0000, 8'hA5, 1'b1, 2'd2};
        vt[6]  = '{4'b0000, 4'b0000, 4'b0000, 8'hA5, 1'b1, 2'd2};
        vt[7]  = '{4'b1010, 4'b1000, 4'b0000, 8'hA5, 1'b1, 2'd2};
        vt[8]  = '{4'b1010, 4'b0000, 4'b1000, 8'h3C, 1'b1, 2'd3};
        vt[9]  = '{4'b1010, 4'b0000, 4'b0000, 8'h3C, 1'b1, 2'd3};
        vt[10] = '{4'b1010, 4'b0000, 4'b0000, 8'h3C, 1'b1, 2'd3};
        vt[11] = '{4'b1010, 4'b0000, 4'b0000, 8'h3C, 1'b1, 2'd3};
        vt[12] = '{4'b1010, 4'b0010, 4'b0000, 8'h3C, 1'b1, 2'd3};
        vt[13] = '{4'b1000, 4'b0000, 4'b0000, 8'h3C, 1'b1, 2'd3};
        vt[14] = '{4'b0010, 4'b0010, 4'b0000, 8'h3C, 1'b1, 2'd3};
        vt[15] = '{4'b0010, 4'b0000, 4'b0010, 8'h5A, 1'b1, 2'd1};

        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Cycle table: single request, lockout, drop in GRANT, wrap, re-request.
        for (int s = 0; s < 16; s++) begin
            req = vt[s].req;
            tick();
            check($sformatf("vec%0d_gnt", s),   32'(gnt),     32'(vt[s].gnt));
            check($sformatf("vec%0d_ack", s),   32'(ack),     32'(vt[s].ack));
            check($sformatf("vec%0d_q", s),     32'(q),       32'(vt[s].q));
            check($sformatf("vec%0d_qv", s),    32'(q_valid), 32'(vt[s].qv));
            check($sformatf("vec%0d_owner", s), 32'(q_owner), 32'(vt[s].own));
        end

        // Clear, then all four requesting: order 0,1,2,3,0 spaced 5 cycles.
        req = '0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_all_zero("clr");
        req = 4'b1111;
        caps = 0;
        last_cyc = 0;
        for (int c = 0; c < 60 && caps < 5; c++) begin
            tick();
            if (ack != 0) begin
                order[caps] = int'(q_owner);
                check($sformatf("rr%0d_ack_onehot", caps), 32'(ack), 32'(4'b0001 << q_owner));
                check($sformatf("rr%0d_q", caps), 32'(q), 32'(din[8*q_owner +: 8]));
                if (caps > 0) check($sformatf("rr%0d_spacing", caps), 32'(c - last_cyc), 32'd5);
                last_cyc = c;
                caps++;
            end
        end
        check("rr_capture_count", 32'(caps), 32'd5);
        for (int k = 0; k < caps; k++)
            check($sformatf("rr%0d_owner", k), 32'(order[k]), 32'(k % 4));

        // Clear colliding with a GRANT capture; pointer must return to 0.
        req = '0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        req = 4'b0100;
        wait_ack(20, ok);
        check("clrcap_first_ack_seen", 32'(ok), 32'd1);
        wait_gnt(20, ok);
        check("clrcap_grant_seen", 32'(ok), 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_all_zero("clrcap");
        req = 4'b1001;
        tick();
        check("clrcap_ptr0_gnt", 32'(gnt), 32'h1);
        tick();
        check("clrcap_ptr0_ack", 32'(ack), 32'h1);
        check("clrcap_ptr0_q", 32'(q), 32'h11);

        // Asynchronous reset in HOLD, then first-edge arbitration.
        req = 4'b0100;
        wait_ack(20, ok);
        check("rst_ack_seen", 32'(ok), 32'd1);
        tick();
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        req = 4'b1000;
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        check("rst_first_gnt", 32'(gnt), 32'h8);
        tick();
        check("rst_first_q", 32'(q), 32'h3C);
        req = '0;

        // HOLD=0 instance: two requesters alternate every 3 cycles.
        req_z = 4'b0011;
        caps = 0;
        last_cyc = 0;
        onehot_bad = 0;
        exp_own = 2'd0;
        for (int c = 0; c < 40 && caps < 6; c++) begin
            tick();
            if ($countones(gnt_z) > 1) onehot_bad++;
            if (ack_z != 0) begin
                check($sformatf("h0_%0d_owner", caps), 32'(q_owner_z), 32'(exp_own));
                check($sformatf("h0_%0d_q", caps), 32'(q_z), 32'(din_z[8*exp_own +: 8]));
                if (caps > 0) check($sformatf("h0_%0d_spacing", caps), 32'(c - last_cyc), 32'd3);
                exp_own = exp_own ^ 2'd1;
                last_cyc = c;
                caps++;
            end
        end
        check("h0_capture_count", 32'(caps), 32'd6);
        check("h0_gnt_onehot", 32'(onehot_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/gated_reg_scheduler.md
GATED_REG_SCHEDULER -- requirements
Module: gated_reg_scheduler

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the enable-gated storage register (2..8).
REQ-002 Parameter DW, default 8, data width of the storage register.
REQ-003 Parameter HOLD, default 2, lockout cycles after each capture (0..15); 0 means no lockout.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port clr  input  1  synchronous clear of the stored value and the scheduler state.
REQ-007 Port req  input  NREQ  per-requester write request, level-sensitive.
REQ-008 Port din  input  NREQ*DW  per-requester data; requester i occupies bits [i*DW +: DW].
REQ-009 Port gnt  output  NREQ  registered one-hot grant; all zero when no grant is active.
REQ-010 Port ack  output  NREQ  registered one-hot, one-cycle pulse confirming capture.
REQ-011 Port q  output  DW  stored value.
REQ-012 Port q_valid  output  1  high once q holds a captured value.
REQ-013 Port q_owner  output  clog2(NREQ)  index of the requester whose data is in q.

Function
REQ-014 The block SHALL implement a 3-state FSM: IDLE, GRANT, HOLD.
REQ-015 In IDLE with any req bit high, the FSM SHALL select one requester by round-robin and enter GRANT; gnt SHALL show that requester from the next cycle.
REQ-016 Round-robin search SHALL start at index (last captured owner + 1) mod NREQ; after reset or clr the search SHALL start at index 0.
REQ-017 In GRANT with req[g] still high, the register SHALL capture q <= din[g], set q_valid=1 and q_owner=g, and pulse ack[g] for exactly the following cycle.
REQ-018 In GRANT with req[g] low, the block SHALL perform no capture and no ack, leave the pointer unchanged, and return to IDLE.
REQ-019 After a capture the FSM SHALL enter HOLD for exactly HOLD cycles and then return to IDLE; with HOLD=0 it SHALL go directly from GRANT to IDLE.
REQ-020 gnt SHALL be high only in GRANT and SHALL drop in the cycle ack rises.
REQ-021 Latency: req sampled high in IDLE at edge k gives gnt after edge k, q updated at edge k+1, and ack high for the cycle after edge k+1.
REQ-022 Minimum spacing between captures SHALL be 3+HOLD cycles (IDLE, GRANT and HOLD states, plus one for re-arbitration).
REQ-023 q SHALL change only on a capture or a clear; the internal write enable SHALL be explicitly 0 in every other state and cycle, so no inferred latch exists.
REQ-024 clr SHALL win over any simultaneous capture: q=0, q_valid=0, q_owner=0, gnt=0, ack=0, pointer=0, next state IDLE.
REQ-025 Requests arriving in HOLD SHALL be ignored until IDLE; requesters SHALL keep req high to retain their claim.
REQ-026 A requester holding req continuously SHALL be granted at most once per NREQ captures while other requesters are also requesting.

Reset
REQ-027 With rst_n low, the block SHALL immediately and asynchronously force state=IDLE, gnt=0, ack=0, q=0, q_valid=0, q_owner=0, pointer=0.
REQ-028 Reset asserted during GRANT or HOLD SHALL abort the operation with no capture; after rst_n rises, the first arbitration SHALL take place on the first clock edge.

Verification
REQ-029 NREQ=4, HOLD=2; only req[2]=1 with din[2]=8'hA5 -> gnt=4'b0100 one cycle, then q=8'hA5, q_owner=2, q_valid=1, ack=4'b0100 one cycle, next gnt no earlier than 3 cycles later.
REQ-030 All four req held high, distinct din -> capture order 0,1,2,3,0, each ack one cycle, captures spaced 5 cycles.
REQ-031 req[1] dropped during GRANT of requester 1 -> q unchanged, no ack, FSM returns to IDLE, next grant goes to requester 1 again if it re-requests.
REQ-032 clr in the same cycle as a GRANT capture -> q=0, q_valid=0, ack stays 0, next state IDLE, pointer=0.
REQ-033 rst_n pulled low mid-HOLD between clock edges -> all outputs 0 immediately; after release, req[3] alone is granted on the first edge.
REQ-034 HOLD=0 with req[0] and req[1] both held -> alternating captures every 3 cycles, gnt never two bits high.
